// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e    : 3-bit MDU operation encoding presented on the op port
//   - md_state_e : controller state encoding
//   - default busy-window lengths for multiply and divide
//   - is_long_op : true for ops that run through the busy window
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MUL_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage <-> MDU controller signal bundle.
//   master (pipeline side) drives: start, op, a, b, cancel, d_is_md, mf_sel
//   slave  (mdu_ctrl)      drives: busy, stall, hi, lo, md_out
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        d_is_md;
    logic        mf_sel;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output start, op, a, b, cancel, d_is_md, mf_sel,
        input  busy, stall, hi, lo, md_out
    );

    modport slave (
        input  start, op, a, b, cancel, d_is_md, mf_sel,
        output busy, stall, hi, lo, md_out
    );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply / divide datapath.
//   op_i    : MDU op code (only MULT/MULTU/DIV/DIVU produce results)
//   a_i/b_i : rs / rt operands
//   hi_o    : product[63:32] or remainder
//   lo_o    : product[31:0] or quotient
//   div0_o  : divide op with b_i == 0; hi_o/lo_o are then meaningless
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div0_o
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic        [31:0] quo;
    logic        [31:0] rem;

    always_comb begin
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u = {32'b0, a_i} * {32'b0, b_i};

        // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps to
        // 0x80000000 instead of relying on signed-overflow semantics.
        a_neg = (op_i == MD_DIV) && a_i[31];
        b_neg = (op_i == MD_DIV) && b_i[31];
        a_mag = a_neg ? (32'd0 - a_i) : a_i;
        b_mag = b_neg ? (32'd0 - b_i) : b_i;
        // Keep the divider's input defined when b is zero; the result is discarded.
        if (b_mag == 32'd0) begin
            quo_u = 32'd0;
            rem_u = 32'd0;
        end else begin
            quo_u = a_mag / b_mag;
            rem_u = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
        rem = a_neg ? (32'd0 - rem_u) : rem_u;

        hi_o   = 32'd0;
        lo_o   = 32'd0;
        div0_o = 1'b0;
        case (op_i)
            MD_MULT:  {hi_o, lo_o} = prod_s;
            MD_MULTU: {hi_o, lo_o} = prod_u;
            MD_DIV, MD_DIVU: begin
                hi_o   = rem;
                lo_o   = quo;
                div0_o = (b_i == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller owning HI/LO.
//   clk    : core clock
//   reset  : synchronous active-high reset
//   md_io  : mdu_ctrl_if.slave
//     start/op/a/b/cancel : E-stage MDU request and flush
//     d_is_md             : D-stage instruction depends on the MDU
//     mf_sel              : md_out select (0 = LO, 1 = HI)
//     busy/stall          : op in flight / D-stage stall request
//     hi/lo/md_out        : architectural HI/LO and selected result
// Multiply/divide results are computed when the op is accepted, held in
// pending registers for the fixed busy window, then committed to HI/LO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,  // >= 1
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF   // >= 1
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  md_io
);

    localparam int unsigned CntMax = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    md_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic [31:0]       ar_hi;
    logic [31:0]       ar_lo;
    logic              ar_div0;
    logic              req_ok;
    logic              long_go;
    logic              is_mul;

    mdu_arith u_arith (
        .op_i   (md_io.op),
        .a_i    (md_io.a),
        .b_i    (md_io.b),
        .hi_o   (ar_hi),
        .lo_o   (ar_lo),
        .div0_o (ar_div0)
    );

    assign req_ok  = md_io.start & ~md_io.cancel;
    assign long_go = req_ok & is_long_op(md_io.op);
    assign is_mul  = (md_io.op == MD_MULT) || (md_io.op == MD_MULTU);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                // Only accept in IDLE; a start while BUSY is silently dropped.
                if (long_go) begin
                    pend_hi_d = ar_hi;
                    pend_lo_d = ar_lo;
                    pend_wr_d = ~ar_div0;
                    cnt_d     = is_mul ? CntW'(MUL_CYCLES) : CntW'(DIV_CYCLES);
                    state_d   = BUSY;
                end else if (req_ok) begin
                    if (md_io.op == MD_MTHI) hi_d = md_io.a;
                    if (md_io.op == MD_MTLO) lo_d = md_io.a;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md_io.busy   = (state_q == BUSY);
    // Stall already in the accept cycle so the dependent D-stage op waits.
    assign md_io.stall  = md_io.d_is_md & ((state_q == BUSY) | long_go);
    assign md_io.hi     = hi_q;
    assign md_io.lo     = lo_q;
    assign md_io.md_out = md_io.mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases followed by random ops,
// compared against a 64-bit arithmetic model of HI/LO.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int unsigned MulN = 5;
    localparam int unsigned DivN = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if md_if ();

    mdu_ctrl #(
        .MUL_CYCLES (MulN),
        .DIV_CYCLES (DivN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md_io (md_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md_if.start  = 1'b0;
        md_if.op     = 3'd0;
        md_if.a      = 32'd0;
        md_if.b      = 32'd0;
        md_if.cancel = 1'b0;
    endtask

    // Architectural result of a multiply/divide from plain 64-bit arithmetic.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] h,
                                   output logic [31:0] l, output bit wr);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        wr = 1'b0;
        case (op)
            3'd1: begin p = sa * sb; wr = 1'b1; end
            3'd2: begin p = ua * ub; wr = 1'b1; end
            3'd3: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; wr = 1'b1;
            end
            3'd4: if (b != 32'd0) begin
                q = ua / ub; r = ua % ub; p = {r[31:0], q[31:0]}; wr = 1'b1;
            end
            default: ;
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, md_if.hi, m_hi);
        check({tag, "_lo"}, md_if.lo, m_lo);
        md_if.mf_sel = 1'b0;
        #1 check({tag, "_mdout_lo"}, md_if.md_out, m_lo);
        md_if.mf_sel = 1'b1;
        #1 check({tag, "_mdout_hi"}, md_if.md_out, m_hi);
        md_if.mf_sel = 1'b0;
    endtask

    // Present one op for one edge and follow it through to completion.
    // Long ops get a stray start (random op, random cancel) in busy cycle 2.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cxl, input logic dmd);
        logic [31:0] eh, el;
        bit wr;
        bit long_op;
        int unsigned n;
        long_op = (op >= 3'd1) && (op <= 3'd4) && !cxl;
        n = (op == 3'd1 || op == 3'd2) ? MulN : DivN;
        ref_op(op, a, b, eh, el, wr);
        md_if.start   = 1'b1;
        md_if.op      = op;
        md_if.a       = a;
        md_if.b       = b;
        md_if.cancel  = cxl;
        md_if.d_is_md = dmd;
        #1;
        check({tag, "_stall_start"}, {31'd0, md_if.stall}, {31'd0, long_op & dmd});
        check({tag, "_busy_start"}, {31'd0, md_if.busy}, 32'd0);
        step();
        idle_inputs();
        if (long_op) begin
            for (int i = 1; i <= int'(n); i++) begin
                if (i == 2) begin
                    md_if.start  = 1'b1;
                    md_if.op     = 3'($urandom_range(0, 7));
                    md_if.a      = $urandom;
                    md_if.b      = $urandom;
                    md_if.cancel = 1'($urandom_range(0, 1));
                end else if (i == 3) begin
                    idle_inputs();
                end
                #1;
                check({tag, "_busy_win"}, {31'd0, md_if.busy}, 32'd1);
                check({tag, "_stall_win"}, {31'd0, md_if.stall}, {31'd0, dmd});
                check({tag, "_hi_hold"}, md_if.hi, m_hi);
                check({tag, "_lo_hold"}, md_if.lo, m_lo);
                step();
            end
            if (wr) begin
                m_hi = eh;
                m_lo = el;
            end
        end else if (!cxl) begin
            if (op == 3'd5) m_hi = a;
            if (op == 3'd6) m_lo = a;
        end
        check({tag, "_busy_done"}, {31'd0, md_if.busy}, 32'd0);
        check({tag, "_stall_done"}, {31'd0, md_if.stall}, 32'd0);
        check_regs(tag);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        reset = 1'b1;
        idle_inputs();
        md_if.d_is_md = 1'b1;
        md_if.mf_sel  = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, md_if.busy}, 32'd0);
        check("rst_stall", {31'd0, md_if.stall}, 32'd0);
        check("rst_hi", md_if.hi, 32'd0);
        check("rst_lo", md_if.lo, 32'd0);
        check("rst_mdout", md_if.md_out, 32'd0);

        issue("mult", 3'd1, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b1);
        check("mult_hi_k", md_if.hi, 32'hFFFF_FFFF);
        check("mult_lo_k", md_if.lo, 32'hFFFF_FFF4);
        issue("multu", 3'd2, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b1);
        check("multu_hi_k", md_if.hi, 32'h0000_0003);
        check("multu_lo_k", md_if.lo, 32'hFFFF_FFF4);
        issue("divu", 3'd4, 32'd7, 32'd2, 1'b0, 1'b1);
        check("divu_hi_k", md_if.hi, 32'd1);
        check("divu_lo_k", md_if.lo, 32'd3);
        issue("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_hi_k", md_if.hi, 32'hFFFF_FFFF);
        check("div_lo_k", md_if.lo, 32'hFFFF_FFFD);

        issue("mthi", 3'd5, 32'h1111_1111, 32'd0, 1'b0, 1'b1);
        issue("mtlo", 3'd6, 32'h2222_2222, 32'd0, 1'b0, 1'b1);
        issue("div0", 3'd3, 32'd1234, 32'd0, 1'b0, 1'b1);
        check("div0_hi_k", md_if.hi, 32'h1111_1111);
        check("div0_lo_k", md_if.lo, 32'h2222_2222);
        issue("divu0", 3'd4, 32'd99, 32'd0, 1'b0, 1'b0);

        issue("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("div_ovf_hi_k", md_if.hi, 32'd0);
        check("div_ovf_lo_k", md_if.lo, 32'h8000_0000);

        issue("cxl_mult", 3'd1, 32'd7, 32'd9, 1'b1, 1'b1);
        issue("cxl_mthi", 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
        issue("cxl_mtlo", 3'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        issue("op_none", 3'd0, 32'hCAFE_F00D, 32'd3, 1'b0, 1'b1);
        issue("op_undef", 3'd7, 32'hCAFE_F00D, 32'd3, 1'b0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 9));
                default: r_b = $urandom;
            endcase
            issue("rnd", r_op, r_a, r_b, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
        end

        // Reset in busy cycle 3 of a divide discards the pending result.
        issue("pre_rst", 3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0);
        md_if.start   = 1'b1;
        md_if.op      = 3'd3;
        md_if.a       = 32'd100;
        md_if.b       = 32'd7;
        md_if.d_is_md = 1'b1;
        step();
        idle_inputs();
        check("mid_busy1", {31'd0, md_if.busy}, 32'd1);
        step();
        step();
        check("mid_busy3", {31'd0, md_if.busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        check("mid_rst_busy", {31'd0, md_if.busy}, 32'd0);
        check("mid_rst_stall", {31'd0, md_if.stall}, 32'd0);
        check_regs("mid_rst");
        for (int i = 0; i < int'(DivN) + 2; i++) begin
            step();
            check("post_rst_busy", {31'd0, md_if.busy}, 32'd0);
            check("post_rst_hi", md_if.hi, 32'd0);
            check("post_rst_lo", md_if.lo, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the E stage of the pipelined MIPS core.
- Owns the HI/LO registers and sequences MULT/MULTU/DIV/DIVU through a fixed-latency busy window.
- Generates the D-stage stall request for MDU-dependent instructions and drives the HI/LO result selection feeding the E-stage forwarding/result mux.
- Accepts an exception cancel so a flushed instruction never commits to HI/LO.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an MDU op this cycle (op valid).
- op  in  3  MDU operation code (package encoding).
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- cancel  in  1  exception/interrupt flush of the E-stage instruction; blocks commit.
- d_is_md  in  1  D-stage instruction reads or writes HI/LO or is an MDU op.
- mf_sel  in  1  result select: 0 = LO, 1 = HI (MFLO/MFHI).
- busy  out  1  MDU operation in flight.
- stall  out  1  D-stage stall request.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_out  out  32  mf_sel ? hi : lo.

Behaviour:
- One clock domain; reset is synchronous and active-high; the clock port is clk and the reset port is reset.
- Reset values: state IDLE, counter 0, busy 0, hi 0, lo 0, so md_out 0 and stall 0.
- State machine:
  - IDLE: on edge with start & ~cancel & op ∈ {MULT, MULTU, DIV, DIVU}:
    - latch product/quotient into pending regs;
    - load counter with MUL_CYCLES or DIV_CYCLES;
    - go BUSY.
  - IDLE, MTHI/MTLO: on edge with start & ~cancel, hi <= a (MTHI) or lo <= a (MTLO); stays IDLE, no busy.
  - BUSY: each edge decrements counter. At the edge where counter == 1: hi/lo <= pending, go IDLE.
- Latency: start sampled at edge t0.
  - busy = 1 for exactly N cycles (t0+1 .. t0+N).
  - New hi/lo are visible in cycle t0+N+1, the first cycle busy = 0.
- busy is registered; it is 1 iff state == BUSY.
- stall = d_is_md & (busy | (start & op ∈ {MULT, MULTU, DIV, DIVU} & ~cancel)). This is combinational.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned.
- Boundary conditions:
  - Divide by zero (b == 0, DIV or DIVU): the busy window still runs for DIV_CYCLES; hi/lo are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (no trap).
  - start while BUSY: ignored; no restart and no HI/LO write. Stall prevents this in the pipeline, but the block must tolerate it.
  - cancel with start: the op is fully suppressed, including MTHI/MTLO.
  - cancel during BUSY: ignored; the committed operation completes.
  - reset mid-operation: immediate return to IDLE; hi/lo cleared; the pending result is discarded.
  - op == NONE or undefined with start: no effect.
- md_out is combinational from registered hi/lo; there is no bypass of the pending result.

Decomposition:
- Shared package (mdu_pkg), holding:
  - the op encoding: MD_NONE = 0, MD_MULT = 1, MD_MULTU = 2, MD_DIV = 3, MD_DIVU = 4, MD_MTHI = 5, MD_MTLO = 6 (3 bits);
  - the state encoding: IDLE, BUSY;
  - default latency constants.
- One sub-module is natural: mdu_arith, a combinational multiply/divide producing {hi_next, lo_next, div0}. The controller holds the FSM, counter, pending registers, HI/LO and stall logic.

Test Plan:
- Signed multiply:
  - Stimulus: reset, then MULT with a = 0xFFFFFFFD (-3), b = 4.
  - Required response: busy high for 5 cycles; afterwards hi = 0xFFFFFFFF, lo = 0xFFFFFFF4. MULTU with the same operands gives hi = 0x00000003, lo = 0xFFFFFFF4.
- Divides:
  - DIVU a = 7, b = 2: busy for 10 cycles, then lo = 3, hi = 1.
  - DIV a = 0xFFFFFFF9 (-7), b = 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Divide by zero:
  - Stimulus: MTHI 0x11111111, then MTLO 0x22222222 (visible the next cycle, busy stays 0); then DIV with b = 0.
  - Required response: busy for 10 cycles; afterwards hi/lo remain 0x11111111 / 0x22222222.
- Stall and mid-operation behaviour:
  - Stimulus: d_is_md = 1 held through a MULT.
  - Required response: stall = 1 in the start cycle and all 5 busy cycles, then 0. A second start during BUSY changes nothing. mf_sel toggling switches md_out between lo and hi.
- Cancel:
  - Stimulus: start with MULT and cancel = 1.
  - Required response: busy stays 0, stall = 0, hi/lo unchanged. Cancel asserted mid-BUSY does not stop completion.
- Reset mid-operation:
  - Stimulus: assert reset in busy cycle 3 of a DIV.
  - Required response: next cycle busy = 0, hi = lo = 0, and no later write occurs.
